intrp_responder: RTL and testbench

INTRP_RESPONDER -- requirements
Module: intrp_responder

---
 rtl/intrp_responder_if.sv | 34 +++
 rtl/intrp_responder.sv | 202 ++++++++++++++++++++
 tb/tb_intrp_responder.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/intrp_responder_if.sv
// Command, response and host-queue signals for the interrupt responder.
// The slave modport is the responder side; master is the AFU/host side.
interface intrp_responder_if;
  logic        cmd_valid;
  logic [7:0]  cmd_opcode;
  logic [15:0] cmd_afutag;
  logic [67:0] cmd_obj;
  logic [19:0] cmd_pasid;
  logic [11:0] cmd_actag;

  logic        rsp_valid;
  logic [7:0]  rsp_opcode;
  logic [15:0] rsp_afutag;
  logic [3:0]  rsp_code;

  logic        intr_valid;
  logic [63:0] intr_src;
  logic [19:0] intr_pasid;
  logic        intr_pop;

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_afutag, cmd_obj, cmd_pasid, cmd_actag,
    output rsp_valid, rsp_opcode, rsp_afutag, rsp_code,
    output intr_valid, intr_src, intr_pasid,
    input  intr_pop
  );

  modport master (
    output cmd_valid, cmd_opcode, cmd_afutag, cmd_obj, cmd_pasid, cmd_actag,
    input  rsp_valid, rsp_opcode, rsp_afutag, rsp_code,
    input  intr_valid, intr_src, intr_pasid,
    output intr_pop
  );
endinterface

// File: rtl/intrp_responder.sv
// Interrupt request responder: answers one command at a time with a delayed
// INTRP_RESP, queues accepted interrupts for the host, and retries via INTRP_RDY.
module intrp_responder #(
  parameter int QDEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  intrp_responder_if.slave    bus,
  input  logic [3:0]          resp_delay,
  input  logic                force_retry,
  output logic                proto_err,
  output logic [15:0]         done_cnt
);

  localparam int AW = $clog2(QDEPTH);

  localparam logic [7:0] OP_INTRP_REQ  = 8'h58;
  localparam logic [7:0] OP_INTRP_RESP = 8'h0C;
  localparam logic [7:0] OP_INTRP_RDY  = 8'h1A;

  localparam logic [3:0] CODE_DONE    = 4'h0;
  localparam logic [3:0] CODE_RTY_REQ = 4'h2;
  localparam logic [3:0] CODE_PENDING = 4'h4;
  localparam logic [3:0] CODE_FAILED  = 4'hE;

  localparam logic [AW:0] QFULL = (AW+1)'(QDEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DELAY,
    S_PENDING,
    S_RDY
  } state_e;

  typedef struct packed {
    logic [63:0] src;
    logic [19:0] pasid;
  } entry_t;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  op_q, op_d;
  logic [15:0] tag_q, tag_d;
  entry_t      cap_q, cap_d;

  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_opcode_q, rsp_opcode_d;
  logic [15:0] rsp_afutag_q, rsp_afutag_d;
  logic [3:0]  rsp_code_q, rsp_code_d;

  logic        proto_err_q, proto_err_d;
  logic [15:0] done_cnt_q, done_cnt_d;

  logic          push, pop;
  entry_t        mem_q [QDEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  // Upper object bits and the acTag carry nothing this responder uses.
  logic unused_cmd_bits;
  assign unused_cmd_bits = ^{bus.cmd_obj[67:64], bus.cmd_actag};

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    tag_d        = tag_q;
    cap_d        = cap_q;
    rsp_valid_d  = 1'b0;
    rsp_opcode_d = rsp_opcode_q;
    rsp_afutag_d = rsp_afutag_q;
    rsp_code_d   = rsp_code_q;
    push         = 1'b0;
    proto_err_d  = proto_err_q | (bus.cmd_valid && (state_q != S_IDLE));

    unique case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          op_d      = bus.cmd_opcode;
          tag_d     = bus.cmd_afutag;
          cap_d     = '{src: bus.cmd_obj[63:0], pasid: bus.cmd_pasid};
          cnt_d     = resp_delay;
          state_d   = S_DELAY;
        end
      end

      S_DELAY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rsp_valid_d  = 1'b1;
          rsp_opcode_d = OP_INTRP_RESP;
          rsp_afutag_d = tag_q;
          state_d      = S_IDLE;
          if (op_q != OP_INTRP_REQ) begin
            rsp_code_d = CODE_FAILED;
          end else if (force_retry) begin
            rsp_code_d = CODE_RTY_REQ;
          end else if (count_q == QFULL) begin
            // Fullness uses the registered count: a pop this cycle does not help.
            rsp_code_d = CODE_PENDING;
            state_d    = S_PENDING;
          end else begin
            rsp_code_d = CODE_DONE;
            push       = 1'b1;
          end
        end
      end

      S_PENDING: begin
        if (count_q < QFULL) begin
          rsp_valid_d  = 1'b1;
          rsp_opcode_d = OP_INTRP_RDY;
          rsp_afutag_d = tag_q;
          rsp_code_d   = force_retry ? CODE_RTY_REQ : CODE_DONE;
          state_d      = S_RDY;
        end
      end

      S_RDY: begin
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign done_cnt_d = done_cnt_q + 16'(push);

  // Host queue bookkeeping; pointers wrap naturally since QDEPTH is a power of 2.
  assign pop = (count_q != '0) && bus.intr_pop;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      op_q         <= '0;
      tag_q        <= '0;
      cap_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_opcode_q <= '0;
      rsp_afutag_q <= '0;
      rsp_code_q   <= '0;
      proto_err_q  <= 1'b0;
      done_cnt_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      tag_q        <= tag_d;
      cap_q        <= cap_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_opcode_q <= rsp_opcode_d;
      rsp_afutag_q <= rsp_afutag_d;
      rsp_code_q   <= rsp_code_d;
      proto_err_q  <= proto_err_d;
      done_cnt_q   <= done_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // NOTE: queue storage is deliberately not reset; validity comes from
  // count_q, and the head is masked to zero whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= cap_q;
    end
  end

  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_opcode = rsp_opcode_q;
  assign bus.rsp_afutag = rsp_afutag_q;
  assign bus.rsp_code   = rsp_code_q;

  assign bus.intr_valid = (count_q != '0);
  assign bus.intr_src   = bus.intr_valid ? mem_q[rd_ptr_q].src   : 64'd0;
  assign bus.intr_pasid = bus.intr_valid ? mem_q[rd_ptr_q].pasid : 20'd0;

  assign proto_err = proto_err_q;
  assign done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_intrp_responder.sv
// Directed self-checking bench for intrp_responder: each task drives one
// scenario and compares against hand-computed values.
module tb_intrp_responder;

  logic        clk;
  logic        rst_n;
  logic [3:0]  resp_delay;
  logic        force_retry;
  logic        proto_err;
  logic [15:0] done_cnt;

  int tests;
  int failed;

  intrp_responder_if ifc ();

  intrp_responder #(.QDEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (ifc),
    .resp_delay  (resp_delay),
    .force_retry (force_retry),
    .proto_err   (proto_err),
    .done_cnt    (done_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    ifc.cmd_valid = 1'b0;
    ifc.intr_pop  = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  // Drives a command for one cycle; returns one cycle after the command cycle.
  task automatic send_cmd(input logic [7:0] op, input logic [15:0] tag,
                          input logic [63:0] src, input logic [19:0] pasid);
    ifc.cmd_valid  = 1'b1;
    ifc.cmd_opcode = op;
    ifc.cmd_afutag = tag;
    ifc.cmd_obj    = {4'hF, src};
    ifc.cmd_pasid  = pasid;
    ifc.cmd_actag  = 12'hABC;
    step();
    ifc.cmd_valid  = 1'b0;
  endtask

  // Waits (bounded) for rsp_valid; lat is the cycle index relative to the command cycle.
  task automatic wait_rsp(input int start, output int lat);
    lat = start;
    while (ifc.rsp_valid !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ifc.cmd_valid = 1'b0;
    ifc.intr_pop  = 1'b0;
    resp_delay    = 4'd0;
    force_retry   = 1'b0;
    step();
    tests++; if (ifc.rsp_valid !== 1'b0) begin failed++; $display("FAIL reset_rsp_valid: got %h expected 0", ifc.rsp_valid); end
    tests++; if (ifc.rsp_opcode !== 8'h00) begin failed++; $display("FAIL reset_rsp_opcode: got %h expected 00", ifc.rsp_opcode); end
    tests++; if (ifc.rsp_afutag !== 16'h0000) begin failed++; $display("FAIL reset_rsp_afutag: got %h expected 0000", ifc.rsp_afutag); end
    tests++; if (ifc.rsp_code !== 4'h0) begin failed++; $display("FAIL reset_rsp_code: got %h expected 0", ifc.rsp_code); end
    tests++; if (ifc.intr_valid !== 1'b0) begin failed++; $display("FAIL reset_intr_valid: got %h expected 0", ifc.intr_valid); end
    tests++; if (ifc.intr_src !== 64'd0) begin failed++; $display("FAIL reset_intr_src: got %h expected 0", ifc.intr_src); end
    tests++; if (ifc.intr_pasid !== 20'd0) begin failed++; $display("FAIL reset_intr_pasid: got %h expected 0", ifc.intr_pasid); end
    tests++; if (proto_err !== 1'b0) begin failed++; $display("FAIL reset_proto_err: got %h expected 0", proto_err); end
    tests++; if (done_cnt !== 16'd0) begin failed++; $display("FAIL reset_done_cnt: got %h expected 0", done_cnt); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_done();
    int lat;
    apply_reset();
    resp_delay  = 4'd0;
    force_retry = 1'b0;
    send_cmd(8'h58, 16'hC000, 64'h1234, 20'h000AB);
    wait_rsp(1, lat);
    tests++; if (lat !== 2) begin failed++; $display("FAIL done_latency: got %0d expected 2", lat); end
    tests++; if (ifc.rsp_opcode !== 8'h0C) begin failed++; $display("FAIL done_opcode: got %h expected 0c", ifc.rsp_opcode); end
    tests++; if (ifc.rsp_code !== 4'h0) begin failed++; $display("FAIL done_code: got %h expected 0", ifc.rsp_code); end
    tests++; if (ifc.rsp_afutag !== 16'hC000) begin failed++; $display("FAIL done_afutag: got %h expected c000", ifc.rsp_afutag); end
    tests++; if (ifc.intr_src !== 64'h1234) begin failed++; $display("FAIL done_intr_src: got %h expected 1234", ifc.intr_src); end
    tests++; if (ifc.intr_pasid !== 20'h000AB) begin failed++; $display("FAIL done_intr_pasid: got %h expected 000ab", ifc.intr_pasid); end
    tests++; if (done_cnt !== 16'd1) begin failed++; $display("FAIL done_cnt: got %0d expected 1", done_cnt); end
    step();
    tests++; if (ifc.rsp_valid !== 1'b0) begin failed++; $display("FAIL done_rsp_one_cycle: got %h expected 0", ifc.rsp_valid); end
    ifc.intr_pop = 1'b1;
    step();
    ifc.intr_pop = 1'b0;
    tests++; if (ifc.intr_valid !== 1'b0) begin failed++; $display("FAIL done_pop_empty: got %h expected 0", ifc.intr_valid); end
  endtask

  task automatic test_retry();
    int lat;
    apply_reset();
    resp_delay  = 4'd5;
    force_retry = 1'b1;
    send_cmd(8'h58, 16'h0042, 64'hDEAD, 20'h00001);
    wait_rsp(1, lat);
    tests++; if (lat !== 7) begin failed++; $display("FAIL retry_latency: got %0d expected 7", lat); end
    tests++; if (ifc.rsp_code !== 4'h2) begin failed++; $display("FAIL retry_code: got %h expected 2", ifc.rsp_code); end
    tests++; if (ifc.rsp_afutag !== 16'h0042) begin failed++; $display("FAIL retry_afutag: got %h expected 0042", ifc.rsp_afutag); end
    tests++; if (ifc.intr_valid !== 1'b0) begin failed++; $display("FAIL retry_queue_empty: got %h expected 0", ifc.intr_valid); end
    tests++; if (done_cnt !== 16'd0) begin failed++; $display("FAIL retry_done_cnt: got %0d expected 0", done_cnt); end
    force_retry = 1'b0;
    step();
  endtask

  task automatic test_full_pending();
    int lat;
    logic [63:0] exp_src;
    apply_reset();
    resp_delay  = 4'd0;
    force_retry = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send_cmd(8'h58, 16'(16'h0010 + i), 64'(64'h100 + i), 20'(i));
      wait_rsp(1, lat);
      tests++; if (ifc.rsp_code !== 4'h0) begin failed++; $display("FAIL fill_code[%0d]: got %h expected 0", i, ifc.rsp_code); end
      step();
    end
    send_cmd(8'h58, 16'h0055, 64'h200, 20'h00055);
    wait_rsp(1, lat);
    tests++; if (lat !== 2) begin failed++; $display("FAIL full_latency: got %0d expected 2", lat); end
    tests++; if (ifc.rsp_code !== 4'h4) begin failed++; $display("FAIL full_code: got %h expected 4", ifc.rsp_code); end
    tests++; if (done_cnt !== 16'd4) begin failed++; $display("FAIL full_done_cnt: got %0d expected 4", done_cnt); end
    step();
    step();
    step();
    tests++; if (ifc.rsp_valid !== 1'b0) begin failed++; $display("FAIL pending_quiet: got %h expected 0", ifc.rsp_valid); end
    ifc.intr_pop = 1'b1;
    step();
    ifc.intr_pop = 1'b0;
    tests++; if (ifc.rsp_valid !== 1'b0) begin failed++; $display("FAIL rdy_early: got %h expected 0", ifc.rsp_valid); end
    step();
    tests++; if (ifc.rsp_valid !== 1'b1) begin failed++; $display("FAIL rdy_valid: got %h expected 1", ifc.rsp_valid); end
    tests++; if (ifc.rsp_opcode !== 8'h1A) begin failed++; $display("FAIL rdy_opcode: got %h expected 1a", ifc.rsp_opcode); end
    tests++; if (ifc.rsp_code !== 4'h0) begin failed++; $display("FAIL rdy_code: got %h expected 0", ifc.rsp_code); end
    tests++; if (ifc.rsp_afutag !== 16'h0055) begin failed++; $display("FAIL rdy_afutag: got %h expected 0055", ifc.rsp_afutag); end
    step();
    tests++; if (ifc.rsp_valid !== 1'b0) begin failed++; $display("FAIL rdy_one_cycle: got %h expected 0", ifc.rsp_valid); end
    for (int j = 1; j < 4; j++) begin
      exp_src = 64'(64'h100 + j);
      tests++; if (ifc.intr_src !== exp_src) begin failed++; $display("FAIL drain_order[%0d]: got %h expected %h", j, ifc.intr_src, exp_src); end
      ifc.intr_pop = 1'b1;
      step();
      ifc.intr_pop = 1'b0;
    end
    tests++; if (ifc.intr_valid !== 1'b0) begin failed++; $display("FAIL drain_empty: got %h expected 0", ifc.intr_valid); end
    tests++; if (done_cnt !== 16'd4) begin failed++; $display("FAIL rdy_no_push: got %0d expected 4", done_cnt); end
  endtask

  task automatic test_failed_proto();
    int lat;
    apply_reset();
    resp_delay  = 4'd3;
    force_retry = 1'b0;
    send_cmd(8'h59, 16'h0077, 64'h5555, 20'h00007);
    ifc.cmd_valid  = 1'b1;
    ifc.cmd_opcode = 8'h58;
    ifc.cmd_afutag = 16'h0099;
    step();
    ifc.cmd_valid  = 1'b0;
    wait_rsp(2, lat);
    tests++; if (lat !== 5) begin failed++; $display("FAIL failed_latency: got %0d expected 5", lat); end
    tests++; if (ifc.rsp_opcode !== 8'h0C) begin failed++; $display("FAIL failed_opcode: got %h expected 0c", ifc.rsp_opcode); end
    tests++; if (ifc.rsp_code !== 4'hE) begin failed++; $display("FAIL failed_code: got %h expected e", ifc.rsp_code); end
    tests++; if (ifc.rsp_afutag !== 16'h0077) begin failed++; $display("FAIL failed_afutag: got %h expected 0077", ifc.rsp_afutag); end
    tests++; if (ifc.intr_valid !== 1'b0) begin failed++; $display("FAIL failed_no_push: got %h expected 0", ifc.intr_valid); end
    tests++; if (proto_err !== 1'b1) begin failed++; $display("FAIL proto_err_set: got %h expected 1", proto_err); end
    step();
    wait_rsp(0, lat);
    tests++; if (lat !== 40) begin failed++; $display("FAIL dropped_cmd_responded: got response at %0d expected none", lat); end
    tests++; if (proto_err !== 1'b1) begin failed++; $display("FAIL proto_err_sticky: got %h expected 1", proto_err); end
  endtask

  task automatic test_back_to_back();
    int lat;
    apply_reset();
    resp_delay  = 4'd0;
    force_retry = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send_cmd(8'h58, 16'(16'h0300 + i), 64'(64'h300 + i), 20'(20'h00300 + i));
      wait_rsp(1, lat);
      step();
    end
    ifc.intr_pop = 1'b1;
    step();
    ifc.intr_pop = 1'b0;
    tests++; if (ifc.intr_src !== 64'h301) begin failed++; $display("FAIL b2b_head_after_pop: got %h expected 301", ifc.intr_src); end
    // Push of 0x303 and pop of 0x301 in the same cycle; write pointer wraps.
    send_cmd(8'h58, 16'h0303, 64'h303, 20'h00303);
    ifc.intr_pop = 1'b1;
    step();
    ifc.intr_pop = 1'b0;
    tests++; if (ifc.rsp_code !== 4'h0) begin failed++; $display("FAIL b2b_code: got %h expected 0", ifc.rsp_code); end
    tests++; if (ifc.intr_src !== 64'h302) begin failed++; $display("FAIL b2b_head_302: got %h expected 302", ifc.intr_src); end
    step();
    send_cmd(8'h58, 16'h0304, 64'h304, 20'h00304);
    ifc.intr_pop = 1'b1;
    step();
    ifc.intr_pop = 1'b0;
    tests++; if (ifc.intr_src !== 64'h303) begin failed++; $display("FAIL b2b_head_303: got %h expected 303", ifc.intr_src); end
    tests++; if (ifc.intr_pasid !== 20'h00303) begin failed++; $display("FAIL b2b_pasid_303: got %h expected 00303", ifc.intr_pasid); end
    ifc.intr_pop = 1'b1;
    step();
    ifc.intr_pop = 1'b0;
    tests++; if (ifc.intr_src !== 64'h304) begin failed++; $display("FAIL b2b_head_304: got %h expected 304", ifc.intr_src); end
    ifc.intr_pop = 1'b1;
    step();
    ifc.intr_pop = 1'b0;
    tests++; if (ifc.intr_valid !== 1'b0) begin failed++; $display("FAIL b2b_count_two: got %h expected 0", ifc.intr_valid); end
    tests++; if (done_cnt !== 16'd5) begin failed++; $display("FAIL b2b_done_cnt: got %0d expected 5", done_cnt); end
  endtask

  // Runs straight after test_back_to_back so the response registers hold non-zero values.
  task automatic test_reset_mid();
    int lat;
    resp_delay  = 4'd6;
    force_retry = 1'b0;
    send_cmd(8'h58, 16'hBEEF, 64'h7777, 20'h00077);
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    wait_rsp(0, lat);
    tests++; if (lat !== 40) begin failed++; $display("FAIL mid_reset_no_rsp: got response at %0d expected none", lat); end
    tests++; if (ifc.rsp_opcode !== 8'h00) begin failed++; $display("FAIL mid_reset_opcode: got %h expected 00", ifc.rsp_opcode); end
    tests++; if (ifc.rsp_afutag !== 16'h0000) begin failed++; $display("FAIL mid_reset_afutag: got %h expected 0000", ifc.rsp_afutag); end
    tests++; if (ifc.rsp_code !== 4'h0) begin failed++; $display("FAIL mid_reset_code: got %h expected 0", ifc.rsp_code); end
    tests++; if (ifc.intr_valid !== 1'b0) begin failed++; $display("FAIL mid_reset_intr_valid: got %h expected 0", ifc.intr_valid); end
    tests++; if (done_cnt !== 16'd0) begin failed++; $display("FAIL mid_reset_done_cnt: got %0d expected 0", done_cnt); end
    tests++; if (proto_err !== 1'b0) begin failed++; $display("FAIL mid_reset_proto_err: got %h expected 0", proto_err); end
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    rst_n  = 1'b0;
    ifc.cmd_valid  = 1'b0;
    ifc.cmd_opcode = 8'h00;
    ifc.cmd_afutag = 16'h0000;
    ifc.cmd_obj    = 68'd0;
    ifc.cmd_pasid  = 20'd0;
    ifc.cmd_actag  = 12'd0;
    ifc.intr_pop   = 1'b0;
    resp_delay     = 4'd0;
    force_retry    = 1'b0;

    test_reset();
    test_done();
    test_retry();
    test_full_pending();
    test_failed_proto();
    test_back_to_back();
    test_reset_mid();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
